// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_pkg
// Purpose  : Shared widths, arbiter state encodings and object type codes
//            for the page controllers and the object-drawer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package draw_pkg;

  // Coordinate and object-type field widths (320x240 screen)
  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int TYPE_W = 5;

  // Arbiter state encodings
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DRAW    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  // Object type codes issued by the page controllers
  localparam logic [TYPE_W-1:0] OBJ_NONE     = 5'd0;
  localparam logic [TYPE_W-1:0] OBJ_CLEAR    = 5'd1;
  localparam logic [TYPE_W-1:0] OBJ_PLAYER   = 5'd2;
  localparam logic [TYPE_W-1:0] OBJ_ENEMY    = 5'd3;
  localparam logic [TYPE_W-1:0] OBJ_BULLET   = 5'd4;
  localparam logic [TYPE_W-1:0] OBJ_TITLE    = 5'd9;
  localparam logic [TYPE_W-1:0] OBJ_DIGIT_0  = 5'd16;
  localparam logic [TYPE_W-1:0] OBJ_DIGIT_1  = 5'd17;
  localparam logic [TYPE_W-1:0] OBJ_GAMEOVER = 5'd30;

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Purpose  : Combinational round-robin selector. Returns the first set
//            request at or after (ptr+1) mod N_REQ as a one-hot pick.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  // Walk the slots starting just after ptr, wrapping, and keep the first hit
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!valid && req[i] && (i == ((int'(ptr) + k) % N_REQ))) begin
          pick[i] = 1'b1;
          valid   = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/draw_object_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : draw_object_arbiter
// Purpose  : Round-robin sharing of the single object drawer between the
//            page/scene controllers, with a watchdog that aborts hung draws.
// Revision : 1.0 - initial release
// ============================================================================
module draw_object_arbiter
  import draw_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 100000,
  parameter int TMR_W   = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [X_W*N_REQ-1:0]    req_x,
  input  logic [Y_W*N_REQ-1:0]    req_y,
  input  logic [TYPE_W*N_REQ-1:0] req_type,
  input  logic                    draw_object_done,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    draw_start,
  output logic [X_W-1:0]          draw_x,
  output logic [Y_W-1:0]          draw_y,
  output logic [TYPE_W-1:0]       draw_type,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_grant_idx;
  logic [N_REQ-1:0]  r_grant;
  logic              r_draw_start;
  logic [X_W-1:0]    r_draw_x;
  logic [Y_W-1:0]    r_draw_y;
  logic [TYPE_W-1:0] r_draw_type;
  logic [TMR_W-1:0]  r_timer;

  logic [N_REQ-1:0]  w_pick;
  logic              w_pick_valid;
  logic [PTR_W-1:0]  w_pick_idx;
  logic [X_W-1:0]    w_sel_x;
  logic [Y_W-1:0]    w_sel_y;
  logic [TYPE_W-1:0] w_sel_type;
  logic              w_expire;
  logic              w_finish;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (req),
    .ptr   (r_ptr),
    .pick  (w_pick),
    .valid (w_pick_valid)
  );

  // Route the picked requester's parameters and index to the capture regs
  always_comb begin
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_sel_type = '0;
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) begin
        w_sel_x    = req_x[X_W*i +: X_W];
        w_sel_y    = req_y[Y_W*i +: Y_W];
        w_sel_type = req_type[TYPE_W*i +: TYPE_W];
        w_pick_idx = PTR_W'(i);
      end
    end
  end

  // Draw ends on drawer completion or when the watchdog hits its last cycle
  assign w_expire = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_finish = (r_state == S_DRAW) && (draw_object_done || w_expire);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_pick_valid) w_next_state = S_DRAW;
      S_DRAW:    if (w_finish)     w_next_state = S_RELEASE;
      S_RELEASE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state; a real completion wins over a same-cycle expiry
  always_comb begin
    done        = '0;
    timeout_err = 1'b0;
    busy        = (r_state == S_DRAW) || (r_state == S_RELEASE);
    if (w_finish) begin
      done        = r_grant;
      timeout_err = !draw_object_done;
    end
  end

  // Capture on grant, run the watchdog during the draw, rotate ptr on finish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr        <= PTR_W'(N_REQ - 1);
      r_grant_idx  <= '0;
      r_grant      <= '0;
      r_draw_start <= 1'b0;
      r_draw_x     <= '0;
      r_draw_y     <= '0;
      r_draw_type  <= '0;
      r_timer      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_grant      <= w_pick;
            r_grant_idx  <= w_pick_idx;
            r_draw_start <= 1'b1;
            r_draw_x     <= w_sel_x;
            r_draw_y     <= w_sel_y;
            r_draw_type  <= w_sel_type;
            r_timer      <= '0;
          end
        end
        S_DRAW: begin
          r_timer <= r_timer + 1'b1;
          if (w_finish) begin
            r_grant      <= '0;
            r_draw_start <= 1'b0;
            r_ptr        <= r_grant_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant      = r_grant;
  assign draw_start = r_draw_start;
  assign draw_x     = r_draw_x;
  assign draw_y     = r_draw_y;
  assign draw_type  = r_draw_type;

endmodule
`default_nettype wire

// File: tb/tb_draw_object_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_object_arbiter
// Purpose  : Scoreboard bench for draw_object_arbiter with a model drawer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_object_arbiter;
  import draw_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 50;

  typedef struct {
    logic [N-1:0]      gnt;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [TYPE_W-1:0] t;
    logic              tmo;
    int                len;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        req = '0;
  logic [X_W*N-1:0]    req_x = '0;
  logic [Y_W*N-1:0]    req_y = '0;
  logic [TYPE_W*N-1:0] req_type = '0;
  logic                draw_object_done = 1'b0;
  logic [N-1:0]        grant;
  logic [N-1:0]        done;
  logic                draw_start;
  logic [X_W-1:0]      draw_x;
  logic [Y_W-1:0]      draw_y;
  logic [TYPE_W-1:0]   draw_type;
  logic                busy;
  logic                timeout_err;

  int checks = 0;
  int failures = 0;
  exp_t gq[$];
  exp_t dq[$];
  exp_t mon_e;
  int cyc = 0;
  int grant_cyc = 0;
  logic [N-1:0] prev_grant = '0;

  // drawer model controls (written only by the stimulus process)
  int drw_lat = 5;
  logic [N-1:0] hang_mask = '0;
  logic spur = 1'b0;

  draw_object_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .TMR_W(17)) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_type(req_type), .draw_object_done(draw_object_done), .grant(grant),
    .done(done), .draw_start(draw_start), .draw_x(draw_x), .draw_y(draw_y),
    .draw_type(draw_type), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Model drawer: completes drw_lat cycles into a draw unless the grant is hung
  initial begin : drawer
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (draw_object_done) begin
        draw_object_done = 1'b0;
        cnt = 0;
      end
      if (spur) draw_object_done = 1'b1;
      else if (draw_start) begin
        if ((grant & hang_mask) == '0) begin
          cnt++;
          if (cnt == drw_lat) draw_object_done = 1'b1;
        end
      end else cnt = 0;
    end
  end

  // Monitor: pops expectations when a grant starts and when done pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (grant != '0 && prev_grant == '0) begin
        chk("grant_onehot", 64'($onehot(grant)), 64'd1);
        if (gq.size() == 0) chk("grant_unexpected", grant, '0);
        else begin
          mon_e = gq.pop_front();
          chk("grant", grant, mon_e.gnt);
          chk("grant_start", draw_start, 1);
          chk("grant_x", draw_x, mon_e.x);
          chk("grant_y", draw_y, mon_e.y);
          chk("grant_type", draw_type, mon_e.t);
          grant_cyc = cyc;
        end
      end
      if (grant != '0 && prev_grant != '0 && grant != prev_grant)
        chk("grant_stable", grant, prev_grant);
      if (done != '0) begin
        if (dq.size() == 0) chk("done_unexpected", done, '0);
        else begin
          mon_e = dq.pop_front();
          chk("done", done, mon_e.gnt);
          chk("done_timeout_err", timeout_err, mon_e.tmo);
          chk("done_cycle", 64'(cyc - grant_cyc), 64'(mon_e.len));
          chk("done_x", draw_x, mon_e.x);
          chk("done_y", draw_y, mon_e.y);
          chk("done_type", draw_type, mon_e.t);
        end
      end else if (timeout_err) chk("timeout_without_done", timeout_err, 0);
    end
    prev_grant = grant;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(int i, int x, int y, int t);
    req_x[X_W*i +: X_W]          = X_W'(x);
    req_y[Y_W*i +: Y_W]          = Y_W'(y);
    req_type[TYPE_W*i +: TYPE_W] = TYPE_W'(t);
    req[i]                       = 1'b1;
  endtask

  task automatic push(int i, int x, int y, int t, logic tmo, int len, bit with_done);
    exp_t e;
    e.gnt = N'(1) << i;
    e.x   = X_W'(x);
    e.y   = Y_W'(y);
    e.t   = TYPE_W'(t);
    e.tmo = tmo;
    e.len = len;
    gq.push_back(e);
    if (with_done) dq.push_back(e);
  endtask

  // Let n done pulses happen; requesters not in hold drop req on their done
  task automatic run_done(int n, int budget, logic [N-1:0] hold);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (done != '0) begin
        seen++;
        req = req & ~(done & ~hold);
      end
    end
    chk("done_count", 64'(seen), 64'(n));
  endtask

  task automatic wait_grant(int budget);
    int k = 0;
    while (grant == '0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("grant_seen", 64'(grant != '0), 64'd1);
  endtask

  task automatic chk_reset_outputs(string name);
    chk(name, {grant, done, draw_start, draw_x, draw_y, draw_type, busy, timeout_err}, '0);
  endtask

  int xs[4] = '{10, 90, 170, 319};
  int ys[4] = '{5, 60, 120, 239};
  int ts[4] = '{1, 2, 3, 4};

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_state");
    reset = 1'b0;
    tick();

    // single requester, 20-cycle draw
    drw_lat = 20;
    set_req(0, 110, 76, OBJ_DIGIT_1);
    push(0, 110, 76, 17, 1'b0, 19, 1'b1);
    tick();
    chk("t1_grant_next_cycle", grant, 4'b0001);
    chk("t1_start_next_cycle", draw_start, 1);
    chk("t1_busy", busy, 1);
    run_done(1, 100, '0);
    tick();
    chk("t1_release_grant", grant, '0);
    chk("t1_release_start", draw_start, 0);
    chk("t1_release_busy", busy, 1);
    tick();
    chk("t1_idle_busy", busy, 0);

    // all four continuously requesting from a fresh reset
    reset = 1'b1;
    tick();
    chk_reset_outputs("t2_reset_state");
    reset = 1'b0;
    tick();
    drw_lat = 5;
    for (int i = 0; i < 4; i++) set_req(i, xs[i], ys[i], ts[i]);
    for (int i = 0; i < 5; i++) push(i % 4, xs[i % 4], ys[i % 4], ts[i % 4], 1'b0, 4, 1'b1);
    run_done(5, 200, 4'b1111);
    req = '0;
    tick();
    tick();

    // requester 2 drops req and changes its inputs mid-draw
    drw_lat = 10;
    set_req(2, 200, 100, OBJ_TITLE);
    push(2, 200, 100, 9, 1'b0, 9, 1'b1);
    wait_grant(20);
    repeat (2) @(negedge clk);
    req[2] = 1'b0;
    req_x[X_W*2 +: X_W] = 9'd7;
    req_y[Y_W*2 +: Y_W] = 8'd3;
    req_type[TYPE_W*2 +: TYPE_W] = 5'd30;
    run_done(1, 50, '0);
    tick();
    tick();

    // requester 3 hangs the drawer, watchdog aborts, requester 1 served next
    hang_mask = 4'b1000;
    drw_lat = 5;
    set_req(1, 33, 44, OBJ_PLAYER);
    set_req(3, 300, 200, OBJ_ENEMY);
    push(3, 300, 200, 3, 1'b1, TMO - 1, 1'b1);
    push(1, 33, 44, 2, 1'b0, 4, 1'b1);
    run_done(2, 200, '0);
    hang_mask = '0;
    tick();
    tick();

    // reset mid-draw: no done, then requester 0 wins over 3
    drw_lat = 30;
    set_req(2, 150, 90, OBJ_BULLET);
    push(2, 150, 90, 4, 1'b0, 0, 1'b0);
    wait_grant(20);
    repeat (3) tick();
    #1;
    reset = 1'b1;
    req = '0;
    #1;
    chk_reset_outputs("t5_async_reset");
    tick();
    reset = 1'b0;
    drw_lat = 5;
    set_req(3, 12, 34, OBJ_GAMEOVER);
    set_req(0, 56, 78, OBJ_CLEAR);
    push(0, 56, 78, 1, 1'b0, 4, 1'b1);
    push(3, 12, 34, 30, 1'b0, 4, 1'b1);
    run_done(2, 100, '0);
    tick();
    tick();

    // spurious drawer completion while idle
    spur = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      chk("t6_spur_busy", busy, 0);
      chk("t6_spur_grant", grant, '0);
      chk("t6_spur_done", done, '0);
    end
    spur = 1'b0;
    tick();
    set_req(0, 1, 2, OBJ_DIGIT_0);
    set_req(1, 3, 4, OBJ_DIGIT_1);
    push(0, 1, 2, 16, 1'b0, 4, 1'b1);
    push(1, 3, 4, 17, 1'b0, 4, 1'b1);
    run_done(2, 100, '0);

    repeat (3) tick();
    chk("grant_queue_empty", 64'(gq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
